// File: rtl/caravel_vector_alu_pkg.sv
// Shared constants for the Caravel vector ALU: sizes, opcodes, register
// offsets and the control FSM state type.
package caravel_vector_alu_pkg;

  localparam int          DEF_ELEMS     = 12;
  localparam int          DEF_WIDTH     = 16;
  localparam int          DEF_RWIDTH    = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_MIN     = 4'd6;
  localparam logic [3:0] OP_MAX     = 4'd7;
  localparam logic [3:0] OP_DOT     = 4'd8;
  localparam logic [3:0] OP_ABSDIFF = 4'd9;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_A      = 8'h40;
  localparam logic [7:0] OFF_B      = 8'h80;
  localparam logic [7:0] OFF_R      = 8'hC0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/caravel_vector_alu_lane.sv
// One-element combinational ALU. The top level time-multiplexes this single
// lane across the vector using its element index counter. For DOT the lane
// hands back the element product; the accumulation lives in the top level.
module caravel_vector_alu_lane
  import caravel_vector_alu_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RWIDTH = DEF_RWIDTH
) (
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [3:0]        op_i,
  output logic [RWIDTH-1:0] res_o
);

  logic signed [RWIDTH-1:0] aExt;
  logic signed [RWIDTH-1:0] bExt;
  logic signed [RWIDTH-1:0] diff;
  logic signed [RWIDTH-1:0] prod;

  assign aExt = {{(RWIDTH-WIDTH){a_i[WIDTH-1]}}, a_i};
  assign bExt = {{(RWIDTH-WIDTH){b_i[WIDTH-1]}}, b_i};
  assign diff = aExt - bExt;
  assign prod = aExt * bExt;

  // Select the element result; unused opcodes produce zero
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:         res_o = aExt + bExt;
      OP_SUB:         res_o = diff;
      OP_MUL, OP_DOT: res_o = prod;
      OP_AND:         res_o = aExt & bExt;
      OP_OR:          res_o = aExt | bExt;
      OP_XOR:         res_o = aExt ^ bExt;
      OP_MIN:         res_o = (aExt < bExt) ? aExt : bExt;
      OP_MAX:         res_o = (aExt < bExt) ? bExt : aExt;
      OP_ABSDIFF:     res_o = diff[RWIDTH-1] ? -diff : diff;
      default:        res_o = '0;
    endcase
  end

endmodule

// File: rtl/caravel_vector_alu.sv
// Caravel user-project vector ALU. The management core loads operand vectors
// A and B over Wishbone, starts one operation, and reads R back. One element
// is processed per busy cycle through a shared lane; status goes out on GPIOs.
module caravel_vector_alu
  import caravel_vector_alu_pkg::*;
#(
  parameter int          ELEMS     = DEF_ELEMS,
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          RWIDTH    = DEF_RWIDTH,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  localparam logic [3:0]  LAST_IDX      = 4'(ELEMS - 1);
  localparam logic [37:0] GPIO_OUT_MASK = 38'h00_0005_F000;

  // Register files
  logic [WIDTH-1:0]  aReg_q [ELEMS];
  logic [WIDTH-1:0]  bReg_q [ELEMS];
  logic [RWIDTH-1:0] rReg_q [ELEMS];

  // Control registers
  state_e            state_q, state_d;
  logic              aluRst_q, aluRst_d;
  logic [3:0]        op_q, op_d;
  logic              done_q, done_d;
  logic [RWIDTH-1:0] acc_q, acc_d;
  logic [3:0]        elemIdx_q, elemIdx_d;
  logic              flagOperand_q, flagOperand_d;
  logic              ack_q, ack_d;
  logic [31:0]       datO_q, datO_d;

  logic              busy;
  logic              lastElem;
  logic [RWIDTH-1:0] laneRes;

  // Bus decode
  logic        access;
  logic        inRange;
  logic [7:0]  offset;
  logic [3:0]  addrIdx;
  logic        isCtrl, isStatus, isA, isB, isR;
  logic        wrEn, ctrlWr, aWr, bWr;
  logic        startReq, clearReq;
  logic [31:0] rdData;
  logic        unusedBits;

  assign access   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign inRange  = (wb_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset   = wb_adr_i[7:0];
  assign addrIdx  = offset[5:2];
  assign isCtrl   = inRange && (offset[7:2] == OFF_CTRL[7:2]);
  assign isStatus = inRange && (offset[7:2] == OFF_STATUS[7:2]);
  assign isA      = inRange && (offset[7:6] == OFF_A[7:6]) && (addrIdx <= LAST_IDX);
  assign isB      = inRange && (offset[7:6] == OFF_B[7:6]) && (addrIdx <= LAST_IDX);
  assign isR      = inRange && (offset[7:6] == OFF_R[7:6]) && (addrIdx <= LAST_IDX);

  // Writes need a full-word select and an idle engine
  assign wrEn     = access & wb_we_i & (wb_sel_i == 4'hF) & ~busy;
  assign ctrlWr   = wrEn & isCtrl;
  assign aWr      = wrEn & isA;
  assign bWr      = wrEn & isB;
  assign startReq = ctrlWr & wb_dat_i[1] & ~wb_dat_i[0];
  assign clearReq = ctrlWr & wb_dat_i[0];

  assign lastElem = (elemIdx_q == LAST_IDX);

  assign unusedBits = ^{wb_adr_i[1:0], wb_dat_i[31:WIDTH]};

  caravel_vector_alu_lane #(
    .WIDTH  (WIDTH),
    .RWIDTH (RWIDTH)
  ) u_lane (
    .a_i   (aReg_q[elemIdx_q]),
    .b_i   (bReg_q[elemIdx_q]),
    .op_i  (op_q),
    .res_o (laneRes)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: run for exactly one cycle per element
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (startReq) state_d = ST_RUN;
      ST_RUN:  if (lastElem) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  // Next values for control, accumulator, element index and bus outputs
  always_comb begin
    aluRst_d      = aluRst_q;
    op_d          = op_q;
    done_d        = done_q;
    acc_d         = acc_q;
    elemIdx_d     = elemIdx_q;
    flagOperand_d = aWr | bWr;
    ack_d         = access;
    datO_d        = (access && !wb_we_i) ? rdData : 32'd0;
    if (ctrlWr) begin
      aluRst_d = wb_dat_i[0];
      op_d     = wb_dat_i[7:4];
    end
    if (startReq || clearReq) begin
      done_d    = 1'b0;
      acc_d     = '0;
      elemIdx_d = '0;
    end else if (busy) begin
      acc_d     = acc_q + laneRes;
      elemIdx_d = lastElem ? 4'd0 : elemIdx_q + 4'd1;
      if (lastElem) done_d = 1'b1;
    end
  end

  // Control and bus output registers
  always_ff @(posedge clock) begin
    if (!resetb) begin
      aluRst_q      <= 1'b1;
      op_q          <= '0;
      done_q        <= 1'b0;
      acc_q         <= '0;
      elemIdx_q     <= '0;
      flagOperand_q <= 1'b0;
      ack_q         <= 1'b0;
      datO_q        <= '0;
    end else begin
      aluRst_q      <= aluRst_d;
      op_q          <= op_d;
      done_q        <= done_d;
      acc_q         <= acc_d;
      elemIdx_q     <= elemIdx_d;
      flagOperand_q <= flagOperand_d;
      ack_q         <= ack_d;
      datO_q        <= datO_d;
    end
  end

  // Operand register files, written only while idle
  always_ff @(posedge clock) begin
    if (!resetb) begin
      for (int i = 0; i < ELEMS; i++) begin
        aReg_q[i] <= '0;
        bReg_q[i] <= '0;
      end
    end else begin
      if (aWr) aReg_q[addrIdx] <= wb_dat_i[WIDTH-1:0];
      if (bWr) bReg_q[addrIdx] <= wb_dat_i[WIDTH-1:0];
    end
  end

  // Result file: DOT keeps the running sum in R[0] and zeroes the rest
  always_ff @(posedge clock) begin
    if (!resetb || clearReq) begin
      for (int i = 0; i < ELEMS; i++) rReg_q[i] <= '0;
    end else if (busy) begin
      if (op_q == OP_DOT) begin
        rReg_q[0] <= acc_d;
        if (elemIdx_q != 4'd0) rReg_q[elemIdx_q] <= '0;
      end else begin
        rReg_q[elemIdx_q] <= laneRes;
      end
    end
  end

  // Read data mux; A and B read back sign-extended
  always_comb begin
    rdData = 32'd0;
    if (isCtrl)        rdData = {24'd0, op_q, 2'd0, 1'b0, aluRst_q};
    else if (isStatus) rdData = {30'd0, done_q, busy};
    else if (isA)      rdData = {{(32-WIDTH){aReg_q[addrIdx][WIDTH-1]}}, aReg_q[addrIdx]};
    else if (isB)      rdData = {{(32-WIDTH){bReg_q[addrIdx][WIDTH-1]}}, bReg_q[addrIdx]};
    else if (isR)      rdData = rReg_q[addrIdx];
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = datO_q;

  assign io_out = {19'd0, ~busy, 1'b0, flagOperand_q, op_q, 12'd0};
  assign io_oeb = ~GPIO_OUT_MASK;

endmodule

// File: tb/tb_caravel_vector_alu.sv
// Directed self-checking bench for caravel_vector_alu: Wishbone register
// accesses, element-wise and dot-product operations, busy protection,
// GPIO flags and mid-operation reset.
module tb_caravel_vector_alu;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] CTRL   = BASE + 32'h00;
  localparam logic [31:0] STATUS = BASE + 32'h04;

  logic        clock = 1'b0;
  logic        resetb;
  logic        wbCyc, wbStb, wbWe;
  logic [3:0]  wbSel;
  logic [31:0] wbAdr, wbDatIn;
  logic [31:0] wbDatOut;
  logic        wbAck;
  logic [37:0] ioOut, ioOeb;

  int checkCount = 0;
  int passCount  = 0;

  caravel_vector_alu dut (
    .clock    (clock),
    .resetb   (resetb),
    .wb_cyc_i (wbCyc),
    .wb_stb_i (wbStb),
    .wb_we_i  (wbWe),
    .wb_sel_i (wbSel),
    .wb_adr_i (wbAdr),
    .wb_dat_i (wbDatIn),
    .wb_dat_o (wbDatOut),
    .wb_ack_o (wbAck),
    .io_out   (ioOut),
    .io_oeb   (ioOeb)
  );

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  function automatic logic [31:0] aAddr(input int i);
    return BASE + 32'h40 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] bAddr(input int i);
    return BASE + 32'h80 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] rAddr(input int i);
    return BASE + 32'hC0 + 32'(4 * i);
  endfunction

  // One comparison: count it, and report tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Shared Wishbone handshake; returns once ack is seen (#1 after the edge)
  task automatic wbCycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat);
    logic gotAck;
    gotAck = 1'b0;
    rdat   = 32'd0;
    @(negedge clock);
    wbCyc = 1'b1; wbStb = 1'b1; wbWe = we; wbAdr = adr; wbDatIn = dat; wbSel = sel;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); #1;
      if (wbAck) begin
        gotAck = 1'b1;
        rdat   = wbDatOut;
        break;
      end
    end
    wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
    if (!gotAck) checkOutput("wbAckTimeout", 64'(gotAck), 64'd1);
  endtask

  // Bus write
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wbCycle(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic readReg(input logic [31:0] adr, output logic [31:0] dat);
    wbCycle(1'b0, adr, 32'd0, 4'hF, dat);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] adr, input logic [31:0] expected);
    logic [31:0] got;
    readReg(adr, got);
    checkOutput(tag, 64'(got), 64'(expected));
  endtask

  // Count cycles with flag_alu_rst low, bounded
  task automatic waitIdle(output int lowCycles);
    lowCycles = 0;
    while (ioOut[18] == 1'b0 && lowCycles < 40) begin
      lowCycles++;
      @(posedge clock); #1;
    end
  endtask

  task automatic runOp(input logic [3:0] op, output int lowCycles);
    applyStimulus(CTRL, {24'd0, op, 4'b0010});
    waitIdle(lowCycles);
    checkOutput("opFinished", 64'(ioOut[18]), 64'd1);
  endtask

  initial begin
    int lowCycles;
    logic [31:0] rd;

    resetb = 1'b0;
    wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0; wbSel = 4'h0; wbAdr = '0; wbDatIn = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetAck", 64'(wbAck), 64'd0);
    checkOutput("resetDatO", 64'(wbDatOut), 64'd0);
    checkOutput("resetIoOut", 64'(ioOut), 64'(38'h00_0004_0000));
    checkOutput("ioOeb", 64'(ioOeb), 64'(38'h3F_FFFA_0FFF));
    @(negedge clock);
    resetb = 1'b1;

    $display("[TB] reset register values");
    readCheck("resetCtrl", CTRL, 32'h1);
    readCheck("resetStatus", STATUS, 32'h0);
    readCheck("unmappedRead", BASE + 32'h10, 32'h0);

    $display("[TB] ADD with A[i]=i+1, B[i]=2");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(aAddr(i), 32'(i + 1));
      if (i == 0) begin
        checkOutput("operandFlagHigh", 64'(ioOut[16]), 64'd1);
        @(posedge clock); #1;
        checkOutput("operandFlagLow", 64'(ioOut[16]), 64'd0);
      end
      applyStimulus(bAddr(i), 32'd2);
      if (i == 5) begin
        checkOutput("operandFlagBHigh", 64'(ioOut[16]), 64'd1);
        @(posedge clock); #1;
        checkOutput("operandFlagBLow", 64'(ioOut[16]), 64'd0);
      end
    end
    readCheck("readA2", aAddr(2), 32'd3);
    applyStimulus(aAddr(1), 32'h0000_0055, 4'h3);
    readCheck("partialSelIgnored", aAddr(1), 32'd2);
    applyStimulus(CTRL, 32'h0);
    runOp(4'd0, lowCycles);
    checkOutput("addLowCycles", 64'(lowCycles), 64'd12);
    for (int i = 0; i < 12; i++) readCheck("addR", rAddr(i), 32'(i + 3));
    readCheck("addStatusDone", STATUS, 32'h2);

    $display("[TB] MUL and DOT with A=-3, B=5");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(aAddr(i), 32'h0000_FFFD);
      applyStimulus(bAddr(i), 32'd5);
    end
    readCheck("signExtA0", aAddr(0), 32'hFFFF_FFFD);
    runOp(4'd2, lowCycles);
    readCheck("mulR0", rAddr(0), 32'hFFFF_FFF1);
    readCheck("mulR11", rAddr(11), 32'hFFFF_FFF1);
    runOp(4'd8, lowCycles);
    checkOutput("dotLowCycles", 64'(lowCycles), 64'd12);
    readCheck("dotR0", rAddr(0), 32'hFFFF_FF4C);
    for (int i = 1; i < 12; i++) readCheck("dotRzero", rAddr(i), 32'h0);

    $display("[TB] boundary operands 7FFF / 8000");
    applyStimulus(aAddr(0), 32'h0000_7FFF);
    applyStimulus(bAddr(0), 32'h0000_8000);
    runOp(4'd1, lowCycles);
    readCheck("subR0", rAddr(0), 32'h0000_FFFF);
    runOp(4'd6, lowCycles);
    readCheck("minR0", rAddr(0), 32'hFFFF_8000);
    runOp(4'd7, lowCycles);
    readCheck("maxR0", rAddr(0), 32'h0000_7FFF);
    applyStimulus(CTRL, 32'h0000_0092);
    checkOutput("opFlagsAbsdiff", 64'(ioOut[15:12]), 64'h9);
    waitIdle(lowCycles);
    readCheck("absdiffR0", rAddr(0), 32'h0000_FFFF);
    readCheck("absdiffR4", rAddr(4), 32'h0000_0008);
    runOp(4'd12, lowCycles);
    readCheck("op12R0", rAddr(0), 32'h0);

    $display("[TB] accesses while busy");
    applyStimulus(CTRL, 32'h0000_0002);
    checkOutput("busyFlagLow", 64'(ioOut[18]), 64'd0);
    applyStimulus(aAddr(3), 32'h0000_1234);
    readCheck("busyWriteIgnored", aAddr(3), 32'hFFFF_FFFD);
    applyStimulus(CTRL, 32'h0000_0012);
    checkOutput("busyStartIgnored", 64'(ioOut[15:12]), 64'h0);
    waitIdle(lowCycles);
    checkOutput("busyRunFinished", 64'(ioOut[18]), 64'd1);
    readCheck("busyAddR3", rAddr(3), 32'h0000_0002);
    readCheck("busyAddR0", rAddr(0), 32'hFFFF_FFFF);

    $display("[TB] start with alu_rst set");
    applyStimulus(CTRL, 32'h0000_0003);
    checkOutput("rstStartNoBusy", 64'(ioOut[18]), 64'd1);
    @(posedge clock); #1;
    checkOutput("rstStartNoBusyLater", 64'(ioOut[18]), 64'd1);
    readCheck("rstStatusCleared", STATUS, 32'h0);
    readCheck("rstRCleared", rAddr(3), 32'h0);
    readCheck("rstCtrl", CTRL, 32'h1);
    readCheck("rstKeepsA", aAddr(3), 32'hFFFF_FFFD);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(CTRL, 32'h0000_0022);
    checkOutput("midRunOp", 64'(ioOut[15:12]), 64'h2);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetb = 1'b0;
    @(posedge clock); #1;
    checkOutput("midResetIoOut", 64'(ioOut), 64'(38'h00_0004_0000));
    @(negedge clock);
    resetb = 1'b1;
    readCheck("midResetCtrl", CTRL, 32'h1);
    readCheck("midResetStatus", STATUS, 32'h0);
    readCheck("midResetR0", rAddr(0), 32'h0);
    readCheck("midResetA0", aAddr(0), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
